// File: rtl/imem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : imem_port_arbiter
// Brief   : Single-port instruction SRAM controller arbitrating fetch vs.
//           loader/debug, with halfword-aligned straddling fetch support.
// Rev     : 1.0  initial release
// ============================================================================
module imem_port_arbiter #(
    parameter int              XLEN         = 32,
    parameter int              MEM_WORDS    = 4096,
    parameter logic [XLEN-1:0] BASE_ADDR    = 32'h8000_0000,
    parameter int              STARVE_LIMIT = 4,
    parameter logic [31:0]     NOP_INSTR    = 32'h0000_0013
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         fetch_req_i,
    input  logic [XLEN-1:0]              fetch_addr_i,
    input  logic                         fetch_kill_i,
    output logic                         fetch_gnt_o,
    output logic                         fetch_rvalid_o,
    output logic [31:0]                  fetch_rdata_o,
    output logic                         fetch_err_o,
    input  logic                         ld_req_i,
    input  logic                         ld_we_i,
    input  logic [XLEN-1:0]              ld_addr_i,
    input  logic [31:0]                  ld_wdata_i,
    input  logic [3:0]                   ld_be_i,
    output logic                         ld_gnt_o,
    output logic                         ld_rvalid_o,
    output logic [31:0]                  ld_rdata_o,
    output logic                         ld_err_o,
    output logic                         mem_en_o,
    output logic                         mem_we_o,
    output logic [3:0]                   mem_be_o,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
    output logic [31:0]                  mem_wdata_o,
    input  logic [31:0]                  mem_rdata_i
);

    localparam int              AW           = $clog2(MEM_WORDS);
    localparam logic [XLEN-1:0] C_SPAN       = XLEN'(4 * MEM_WORDS);
    localparam logic [AW-1:0]   C_LAST_IDX   = AW'(MEM_WORDS - 1);
    localparam logic [3:0]      C_STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FETCH_LO = 2'd1,
        S_FETCH_HI = 2'd2,
        S_LOAD_RD  = 2'd3
    } state_t;

    state_t         r_state;
    logic [3:0]     r_starve;
    logic [AW-1:0]  r_idx;
    logic           r_a1;
    logic [15:0]    r_hw;
    logic           r_err_pend;
    logic           r_ld_err;

    state_t         w_nxt_state;
    logic [3:0]     w_nxt_starve;
    logic [AW-1:0]  w_nxt_idx;
    logic           w_nxt_a1;
    logic [15:0]    w_nxt_hw;
    logic           w_nxt_err_pend;
    logic           w_nxt_ld_err;

    logic [XLEN-1:0] w_f_off;
    logic [XLEN-1:0] w_l_off;
    logic            w_f_inr;
    logic            w_l_inr;
    logic [AW-1:0]   w_f_idx;
    logic [AW-1:0]   w_l_idx;
    logic            w_fetch_win;
    logic [15:0]     w_hi_hw;

    assign w_f_off     = fetch_addr_i - BASE_ADDR;
    assign w_l_off     = ld_addr_i - BASE_ADDR;
    assign w_f_inr     = (w_f_off < C_SPAN);
    assign w_l_inr     = (w_l_off < C_SPAN);
    assign w_f_idx     = w_f_off[AW+1:2];
    assign w_l_idx     = w_l_off[AW+1:2];
    assign w_hi_hw     = mem_rdata_i[31:16];
    // Loader has priority unless fetch has been starved for STARVE_LIMIT grants.
    assign w_fetch_win = fetch_req_i && (!ld_req_i || (r_starve == C_STARVE_MAX));

    always_comb begin
        fetch_gnt_o    = 1'b0;
        fetch_rvalid_o = 1'b0;
        fetch_rdata_o  = '0;
        fetch_err_o    = 1'b0;
        ld_gnt_o       = 1'b0;
        ld_rvalid_o    = 1'b0;
        ld_rdata_o     = '0;
        ld_err_o       = 1'b0;
        mem_en_o       = 1'b0;
        mem_we_o       = 1'b0;
        mem_be_o       = '0;
        mem_addr_o     = '0;
        mem_wdata_o    = '0;
        w_nxt_state    = r_state;
        w_nxt_idx      = r_idx;
        w_nxt_a1       = r_a1;
        w_nxt_hw       = r_hw;
        w_nxt_err_pend = r_err_pend;
        w_nxt_ld_err   = r_ld_err;

        case (r_state)
            S_IDLE: begin
                if (w_fetch_win) begin
                    fetch_gnt_o    = 1'b1;
                    mem_en_o       = w_f_inr;
                    mem_addr_o     = w_f_inr ? w_f_idx : '0;
                    w_nxt_idx      = w_f_idx;
                    w_nxt_a1       = fetch_addr_i[1];
                    w_nxt_err_pend = !w_f_inr;
                    w_nxt_state    = S_FETCH_LO;
                end else if (ld_req_i) begin
                    ld_gnt_o   = 1'b1;
                    mem_en_o   = w_l_inr;
                    mem_addr_o = w_l_inr ? w_l_idx : '0;
                    if (ld_we_i) begin
                        mem_we_o    = w_l_inr;
                        mem_be_o    = w_l_inr ? ld_be_i : 4'b0000;
                        mem_wdata_o = w_l_inr ? ld_wdata_i : '0;
                        ld_err_o    = !w_l_inr;
                    end else begin
                        w_nxt_ld_err = !w_l_inr;
                        w_nxt_state  = S_LOAD_RD;
                    end
                end
            end
            S_FETCH_LO: begin
                w_nxt_state = S_IDLE;
                if (!fetch_kill_i) begin
                    if (r_err_pend) begin
                        fetch_rvalid_o = 1'b1;
                        fetch_err_o    = 1'b1;
                        fetch_rdata_o  = NOP_INSTR;
                    end else if (!r_a1) begin
                        fetch_rvalid_o = 1'b1;
                        fetch_rdata_o  = (mem_rdata_i[1:0] == 2'b11) ? mem_rdata_i
                                                                     : {16'h0000, mem_rdata_i[15:0]};
                    end else if (w_hi_hw[1:0] != 2'b11) begin
                        fetch_rvalid_o = 1'b1;
                        fetch_rdata_o  = {16'h0000, w_hi_hw};
                    end else if (r_idx == C_LAST_IDX) begin
                        // Upper half would lie past the last SRAM word: no wrap.
                        fetch_rvalid_o = 1'b1;
                        fetch_err_o    = 1'b1;
                        fetch_rdata_o  = NOP_INSTR;
                    end else begin
                        w_nxt_hw    = w_hi_hw;
                        mem_en_o    = 1'b1;
                        mem_addr_o  = r_idx + AW'(1);
                        w_nxt_state = S_FETCH_HI;
                    end
                end
            end
            S_FETCH_HI: begin
                w_nxt_state = S_IDLE;
                if (!fetch_kill_i) begin
                    fetch_rvalid_o = 1'b1;
                    fetch_rdata_o  = {mem_rdata_i[15:0], r_hw};
                end
            end
            default: begin
                ld_rvalid_o = 1'b1;
                ld_err_o    = r_ld_err;
                ld_rdata_o  = r_ld_err ? 32'h0000_0000 : mem_rdata_i;
                w_nxt_state = S_IDLE;
            end
        endcase

        if (rst_i) begin
            fetch_gnt_o    = 1'b0;
            fetch_rvalid_o = 1'b0;
            fetch_rdata_o  = '0;
            fetch_err_o    = 1'b0;
            ld_gnt_o       = 1'b0;
            ld_rvalid_o    = 1'b0;
            ld_rdata_o     = '0;
            ld_err_o       = 1'b0;
            mem_en_o       = 1'b0;
            mem_we_o       = 1'b0;
            mem_be_o       = '0;
            mem_addr_o     = '0;
            mem_wdata_o    = '0;
        end
    end

    always_comb begin
        w_nxt_starve = r_starve;
        if (!fetch_req_i || fetch_gnt_o) begin
            w_nxt_starve = '0;
        end else if (ld_gnt_o && (r_starve < C_STARVE_MAX)) begin
            w_nxt_starve = r_starve + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_starve   <= '0;
            r_idx      <= '0;
            r_a1       <= 1'b0;
            r_hw       <= '0;
            r_err_pend <= 1'b0;
            r_ld_err   <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_starve   <= w_nxt_starve;
            r_idx      <= w_nxt_idx;
            r_a1       <= w_nxt_a1;
            r_hw       <= w_nxt_hw;
            r_err_pend <= w_nxt_err_pend;
            r_ld_err   <= w_nxt_ld_err;
        end
    end

endmodule
`default_nettype wire
